fp_div_seq: RTL

Sequential IEEE-754 single-precision divider with exponent-dependent precision control, the inverse operation of the team's approximate Booth multiplier datapath. It uses a restoring, one-quotient-bit-per-cycle iteration. It reuses the multiplier's region scheme: the top nibble of the pre-normalised biased exponent selects how many low quotient bits are skipped. It sits beside the multiplier behind a valid/ready handshake, so either can feed the same result capture and ILA probes.

---
 rtl/fp_div_pkg.sv | 23 ++
 rtl/fp_div_seq_if.sv | 17 +
 rtl/fp_div_special.sv | 40 ++++
 rtl/fp_div_seq.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/fp_div_pkg.sv
// Shared types and constants for the sequential single-precision divider.
// Holds the FSM state encoding, IEEE constants and the exponent-region drop table.
// No logic of its own; imported by the divider datapath and its classifier.
package fp_div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIV,
        ST_NORM,
        ST_DONE
    } state_t;

    localparam int          BIAS = 127;
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    // Region 0/F drops nothing, each step towards the 7/8 centre drops two more bits.
    function automatic logic [3:0] drop_of(input logic [3:0] rg);
        logic [2:0] k;
        k = rg[3] ? ~rg[2:0] : rg[2:0];
        return {k, 1'b0};
    endfunction

endpackage

// File: rtl/fp_div_seq_if.sv
// Operand/result handshake bundle between a requester and the divider.
// Pure wiring, no latency.
// Valid/ready on both the operand side and the result side.
interface fp_div_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] q;

    modport master (output in_valid, a, b, out_ready,
                    input  in_ready, out_valid, q);
    modport slave  (input  in_valid, a, b, out_ready,
                    output in_ready, out_valid, q);
endinterface

// File: rtl/fp_div_special.sv
// Classifies a divide operand pair and produces the short-circuit result word.
// Purely combinational, zero latency.
// No handshake; sampled by the divider when it accepts an operand pair.
module fp_div_special
    import fp_div_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        is_special,
    output logic [31:0] spec_q
);

    logic sgn;
    logic a_zero, a_inf, a_nan;
    logic b_zero, b_inf, b_nan;

    assign sgn    = a[31] ^ b[31];
    assign a_zero = (a[30:23] == 8'd0);
    assign b_zero = (b[30:23] == 8'd0);
    assign a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    assign b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    assign a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    assign b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);

    // NaN-producing cases win, then infinities, then zeros; denormals count as zero.
    always_comb begin
        is_special = 1'b1;
        spec_q     = 32'd0;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            spec_q = QNAN;
        end else if (a_inf || b_zero) begin
            spec_q = {sgn, 8'hFF, 23'd0};
        end else if (a_zero || b_inf) begin
            spec_q = {sgn, 31'd0};
        end else begin
            is_special = 1'b0;
        end
    end

endmodule

// File: rtl/fp_div_seq.sv
// Restoring IEEE single divider, one quotient bit per cycle, exponent-region precision drop.
// Latency: N+1 edges from acceptance (N = 25 - drop), 1 edge for special operands.
// Accepts only in IDLE; result held stable in DONE until out_ready.
module fp_div_seq
    import fp_div_pkg::*;
#(
    parameter bit APPROX = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    fp_div_seq_if.slave  bus
);

    state_t             state_q, state_d;
    logic [25:0]        rem_q, rem_d;
    logic [23:0]        mb_q, mb_d;
    logic [24:0]        quot_q, quot_d;
    logic [4:0]         cnt_q, cnt_d;
    logic [3:0]         drop_q, drop_d;
    logic signed [9:0]  epre_q, epre_d;
    logic               sign_q, sign_d;
    logic               spec_q, spec_d;
    logic [31:0]        sres_q, sres_d;
    logic [31:0]        q_q, q_d;
    logic               out_valid_q, out_valid_d;

    logic               is_special;
    logic [31:0]        spec_word;
    logic signed [9:0]  epre_in;
    logic [3:0]         drop_in;
    logic [26:0]        diff;
    logic [25:0]        diff_lo;
    logic               diff_neg;
    logic [4:0]         idx;
    logic signed [9:0]  e_norm;
    logic [22:0]        m_norm;
    logic [31:0]        norm_word;

    fp_div_special u_special (
        .a          (bus.a),
        .b          (bus.b),
        .is_special (is_special),
        .spec_q     (spec_word)
    );

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.q         = q_q;

    assign epre_in  = 10'({2'b00, bus.a[30:23]}) - 10'({2'b00, bus.b[30:23]}) + 10'(BIAS);
    assign drop_in  = APPROX ? drop_of(epre_in[7:4]) : 4'd0;

    // Trial subtraction; the top bit flags a negative result (restore).
    assign diff     = {1'b0, rem_q} - {3'b000, mb_q};
    assign diff_lo  = diff[25:0];
    assign diff_neg = diff[26];
    // Bit position being filled: 24 on the first iteration, drop on the last.
    assign idx      = cnt_q + {1'b0, drop_q} - 5'd1;

    // Normalise the left-aligned quotient (truncating) and clamp the exponent range.
    always_comb begin
        e_norm    = quot_q[24] ? epre_q : epre_q - 10'sd1;
        m_norm    = quot_q[24] ? quot_q[23:1] : quot_q[22:0];
        norm_word = {sign_q, e_norm[7:0], m_norm};
        if (e_norm >= 10'sd255) begin
            norm_word = {sign_q, 8'hFF, 23'd0};
        end else if (e_norm <= 10'sd0) begin
            norm_word = {sign_q, 31'd0};
        end
    end

    // Next-state and datapath update for IDLE -> DIV/NORM -> DONE -> IDLE.
    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        mb_d        = mb_q;
        quot_d      = quot_q;
        cnt_d       = cnt_q;
        drop_d      = drop_q;
        epre_d      = epre_q;
        sign_d      = sign_q;
        spec_d      = spec_q;
        sres_d      = sres_q;
        q_d         = q_q;
        out_valid_d = out_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    sign_d  = bus.a[31] ^ bus.b[31];
                    spec_d  = is_special;
                    sres_d  = spec_word;
                    epre_d  = epre_in;
                    drop_d  = drop_in;
                    mb_d    = {1'b1, bus.b[22:0]};
                    rem_d   = {2'b00, 1'b1, bus.a[22:0]};
                    quot_d  = 25'd0;
                    cnt_d   = 5'd25 - {1'b0, drop_in};
                    state_d = is_special ? ST_NORM : ST_DIV;
                end
            end
            ST_DIV: begin
                quot_d[idx] = ~diff_neg;
                rem_d       = diff_neg ? (rem_q << 1) : (diff_lo << 1);
                cnt_d       = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    state_d = ST_NORM;
                end
            end
            ST_NORM: begin
                q_d         = spec_q ? sres_q : norm_word;
                out_valid_d = 1'b1;
                state_d     = ST_DONE;
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; synchronous reset discards any in-flight operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rem_q       <= '0;
            mb_q        <= '0;
            quot_q      <= '0;
            cnt_q       <= '0;
            drop_q      <= '0;
            epre_q      <= '0;
            sign_q      <= 1'b0;
            spec_q      <= 1'b0;
            sres_q      <= '0;
            q_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            mb_q        <= mb_d;
            quot_q      <= quot_d;
            cnt_q       <= cnt_d;
            drop_q      <= drop_d;
            epre_q      <= epre_d;
            sign_q      <= sign_d;
            spec_q      <= spec_d;
            sres_q      <= sres_d;
            q_q         <= q_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule
